// File: rtl/serial_link_scheduler.sv
// Round-robin owner of one serial line: frames go out as start, length (MSB first), data (LSB first), stop.
// Every bit step is gated by the single-cycle clk_en strobe; all outputs come straight from flops.
module serial_link_scheduler #(
    parameter int N  = 2,
    parameter int LW = 4,
    parameter int DW = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic [N-1:0]    req,
    input  logic [N*LW-1:0] len,
    input  logic [N*DW-1:0] data,
    output logic [N-1:0]    grant,
    output logic            busy,
    output logic            ser_out,
    output logic            ser_valid,
    output logic            done,
    output logic [3:0]      cnt_out
);
    localparam int PW   = (N > 1) ? $clog2(N) : 1;
    localparam int IMAX = (LW > DW) ? LW : DW;
    localparam int IW   = $clog2(IMAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_LEN   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_q, win_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] data_q, data_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          ser_q, ser_d;
    logic          vld_q, vld_d;
    logic          done_q, done_d;

    logic          found;
    logic [PW-1:0] pick;

    // Lengths beyond the payload width would read past the data word.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        if (int'(l) > DW) return LW'(DW);
        return l;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'd1;
    endfunction

    function automatic logic len_bit(input logic [LW-1:0] v, input logic [IW-1:0] i);
        logic [LW-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic logic data_bit(input logic [DW-1:0] v, input logic [IW-1:0] i);
        logic [DW-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    // First requester at or after the pointer, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr_q) + i) % N]) begin
                found = 1'b1;
                pick  = PW'((int'(ptr_q) + i) % N);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        grant_d = grant_q;
        len_d   = len_q;
        data_d  = data_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ser_d   = ser_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clk_en && found) begin
                    state_d = S_START;
                    win_d   = pick;
                    grant_d = {{(N-1){1'b0}}, 1'b1} << pick;
                    len_d   = clamp_len(len[int'(pick)*LW +: LW]);
                    data_d  = data[int'(pick)*DW +: DW];
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    ser_d   = 1'b0;
                    vld_d   = 1'b1;
                end
            end
            S_START: begin
                if (clk_en) begin
                    state_d = S_LEN;
                    idx_d   = IW'(LW - 1);
                    ser_d   = len_bit(len_q, IW'(LW - 1));
                end
            end
            S_LEN: begin
                if (clk_en) begin
                    if (idx_q == '0) begin
                        if (len_q != '0) begin
                            state_d = S_DATA;
                            ser_d   = data_q[0];
                        end else begin
                            state_d = S_STOP;
                            ser_d   = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q - 1'b1;
                        ser_d = len_bit(len_q, idx_q - 1'b1);
                    end
                end
            end
            S_DATA: begin
                if (clk_en) begin
                    cnt_d = sat_inc(cnt_q);
                    if (int'(idx_q) + 1 == int'(len_q)) begin
                        state_d = S_STOP;
                        ser_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        ser_d = data_bit(data_q, idx_q + 1'b1);
                    end
                end
            end
            S_STOP: begin
                if (clk_en) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ser_d   = 1'b1;
                    vld_d   = 1'b0;
                    done_d  = 1'b1;
                    ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;
                end
            end
            default: begin
                // Corrupted encoding: drop the frame without a done pulse.
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                ser_d   = 1'b1;
                vld_d   = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
            len_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            ser_q   <= 1'b1;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            len_q   <= len_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ser_q   <= ser_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign ser_out   = ser_q;
    assign ser_valid = vld_q;
    assign done      = done_q;
    assign cnt_out   = cnt_q;

endmodule

// File: tb/tb_serial_link_scheduler.sv
// Scoreboard bench: a frame-level model pushes the expected per-step outputs at grant time,
// and a monitor compares them against the DUT on every step, hold cycle and reset cycle.
module tb_serial_link_scheduler;
    localparam int N  = 2;
    localparam int LW = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clk_en = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*LW-1:0] len = '0;
    logic [N*DW-1:0] data = '0;
    logic [N-1:0]    grant;
    logic            busy;
    logic            ser_out;
    logic            ser_valid;
    logic            done;
    logic [3:0]      cnt_out;

    serial_link_scheduler #(.N(N), .LW(LW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .req       (req),
        .len       (len),
        .data      (data),
        .grant     (grant),
        .busy      (busy),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .done      (done),
        .cnt_out   (cnt_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         ser;
        logic         vld;
        logic [N-1:0] g;
        logic         busy;
        logic         done;
        logic [3:0]   cnt;
    } rec_t;

    rec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   rem      = 0;
    int   ptr      = 0;
    logic en_seen  = 1'b0;
    logic rst_seen = 1'b0;
    rec_t prev     = '0;
    logic [3:0] last_cnt = 4'd0;

    function automatic void chk(input string nm, input rec_t got, input rec_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual ser=%b vld=%b grant=%b busy=%b done=%b cnt=%0d required ser=%b vld=%b grant=%b busy=%b done=%b cnt=%0d",
                     nm, $time, got.ser, got.vld, got.g, got.busy, got.done, got.cnt,
                     exp.ser, exp.vld, exp.g, exp.busy, exp.done, exp.cnt);
        end
    endfunction

    // One clk_en step of the frame-level model: a grant expands into the full list of line states.
    task automatic model_step();
        int   w;
        int   lc;
        rec_t r;
        if (rem == 0 && req != '0) begin
            w = -1;
            for (int i = 0; i < N; i++)
                if (w < 0 && req[(ptr + i) % N]) w = (ptr + i) % N;
            lc = int'(len[w*LW +: LW]);
            if (lc > DW) lc = DW;
            ptr = (w + 1) % N;
            r = '0;
            r.g[w] = 1'b1;
            r.busy = 1'b1;
            r.vld  = 1'b1;
            r.ser  = 1'b0;
            exp_q.push_back(r);
            for (int b = LW - 1; b >= 0; b--) begin
                r.ser = lc[b];
                exp_q.push_back(r);
            end
            for (int k = 0; k < lc; k++) begin
                r.ser = data[w*DW + k];
                r.cnt = 4'(k);
                exp_q.push_back(r);
            end
            r.ser = 1'b1;
            r.cnt = 4'(lc);
            exp_q.push_back(r);
            r.vld  = 1'b0;
            r.g    = '0;
            r.busy = 1'b0;
            r.done = 1'b1;
            exp_q.push_back(r);
            rem = 3 + LW + lc;
        end
        if (rem > 0) rem--;
    endtask

    task automatic cyc(input logic en, input logic [N-1:0] r,
                       input logic [N*LW-1:0] l, input logic [N*DW-1:0] d);
        @(negedge clk);
        #2;
        clk_en = en;
        req    = r;
        len    = l;
        data   = d;
        if (en && !rst) model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst    = 1'b1;
        clk_en = 1'($urandom % 2);
        exp_q.delete();
        rem = 0;
        ptr = 0;
        @(negedge clk);
        #2;
        rst    = 1'b0;
        clk_en = 1'b0;
    endtask

    task automatic drain_idle();
        int guard;
        guard = 0;
        while (rem != 0 && guard < 200) begin
            cyc(1'b1, '0, '0, '0);
            guard++;
        end
    endtask

    always @(posedge clk) begin
        en_seen  <= clk_en && !rst;
        rst_seen <= rst;
    end

    always @(negedge clk) begin : monitor
        rec_t got;
        rec_t e;
        got = {ser_out, ser_valid, grant, busy, done, cnt_out};
        if (rst_seen) begin
            chk("reset", got, {1'b1, 1'b0, {N{1'b0}}, 1'b0, 1'b0, 4'd0});
            last_cnt = 4'd0;
        end else if (en_seen) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("step", got, e);
                last_cnt = e.cnt;
            end else begin
                chk("idle", got, {1'b1, 1'b0, {N{1'b0}}, 1'b0, 1'b0, last_cnt});
            end
        end else begin
            e = prev;
            e.done = 1'b0;
            chk("hold", got, e);
        end
        prev = got;
    end

    initial begin : stim
        logic [N-1:0]    rv;
        logic [N*LW-1:0] lv;
        logic [N*DW-1:0] dv;
        int              guard;

        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Short frame, strobe every third clock, req dropped after the grant.
        for (int i = 0; i < 42; i++)
            cyc(i % 3 == 2, (i < 3) ? 2'b01 : 2'b00, {4'd0, 4'd3}, {8'h00, 8'b0000_0101});
        drain_idle();

        // Both requesting, one-bit frames: owners must alternate.
        for (int i = 0; i < 40; i++)
            cyc(1'b1, 2'b11, {4'd1, 4'd1}, {8'hA5, 8'h3C});
        drain_idle();

        // Zero-length frame.
        for (int i = 0; i < 8; i++)
            cyc(1'b1, (i < 1) ? 2'b01 : 2'b00, {4'd0, 4'd0}, {8'hFF, 8'hFF});
        drain_idle();

        // Length beyond DW is clamped.
        dv = (N*DW)'($urandom);
        for (int i = 0; i < 16; i++)
            cyc(1'b1, (i < 1) ? 2'b01 : 2'b00, {4'd0, 4'd15}, dv);
        drain_idle();

        // Reset in the middle of the length field; pointer must return to requester 0.
        cyc(1'b1, 2'b01, {4'd0, 4'd0}, '0);
        drain_idle();
        cyc(1'b1, 2'b00, '0, '0);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 2'b11, {4'd5, 4'd5}, {8'h5A, 8'hC3});
        do_reset();
        for (int i = 0; i < 14; i++)
            cyc(1'b1, (i < 1) ? 2'b11 : 2'b00, {4'd2, 4'd2}, {8'h01, 8'h02});
        drain_idle();

        // Long stall inside the data field.
        dv = (N*DW)'($urandom);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, (i < 1) ? 2'b01 : 2'b00, {4'd0, 4'd8}, dv);
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 2'b10, {4'd7, 4'd1}, ~dv);
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 2'b00, '0, '0);
        drain_idle();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 400 == 0) begin
                do_reset();
            end else begin
                rv = N'($urandom);
                lv = (N*LW)'($urandom);
                dv = (N*DW)'($urandom);
                cyc(($urandom % 3) == 0, rv, lv, dv);
            end
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            cyc(1'b1, '0, '0, '0);
            guard++;
        end
        cyc(1'b0, '0, '0, '0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: actual pending=%0d required pending=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
